// File: rtl/clkdiv_ctrl_if.sv
// Config port of the two-channel clock divider: one valid/ready transfer
// selects a channel and either starts it with a new divisor or stops it.
interface clkdiv_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_sel;
    logic             cfg_en;
    logic [CNT_W-1:0] cfg_div;

    modport master (
        output cfg_valid, cfg_sel, cfg_en, cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_en, cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Two independent programmable clock dividers with tick strobes. Config
// updates are buffered and applied only at half-period boundaries.
module clkdiv_ctrl #(
    parameter int          CNT_W    = 16,
    parameter int unsigned DIV0_RST = 212,
    parameter int unsigned DIV1_RST = 9
) (
    input  logic         clk200M_in,
    input  logic         rst_n,
    clkdiv_ctrl_if.slave cfg,
    output logic [1:0]   ch_out,
    output logic [1:0]   ch_tick,
    output logic [1:0]   ch_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [CNT_W-1:0] div_q   [2];
    logic [CNT_W-1:0] div_d   [2];
    logic [CNT_W-1:0] sdiv_q  [2];
    logic [CNT_W-1:0] sdiv_d  [2];
    logic [1:0]       sen_q, sen_d;
    logic [1:0]       out_q, out_d;
    logic [1:0]       tick_q, tick_d;
    logic [1:0]       wr, term;

    always_comb begin
        ch_busy = '0;
        term    = '0;
        wr      = '0;
        for (int i = 0; i < 2; i++) begin
            ch_busy[i] = (state_q[i] == S_PEND);
            term[i]    = (cnt_q[i] == div_q[i]);
            wr[i]      = cfg.cfg_valid && !ch_busy[i] && (cfg.cfg_sel == 1'(i));
        end
    end

    assign cfg.cfg_ready = ~ch_busy[cfg.cfg_sel];

    // NOTE: every next-state signal takes its hold value before the case
    // statement, so no path through the block can leave one unassigned.
    always_comb begin
        out_d  = out_q;
        tick_d = '0;
        sen_d  = sen_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            div_d[i]   = div_q[i];
            sdiv_d[i]  = sdiv_q[i];

            unique case (state_q[i])
                S_IDLE: begin
                    cnt_d[i] = '0;
                    out_d[i] = 1'b0;
                    if (wr[i] && cfg.cfg_en) begin
                        div_d[i]   = cfg.cfg_div;
                        state_d[i] = S_RUN;
                    end
                end
                S_RUN, S_PEND: begin
                    if (term[i]) begin
                        cnt_d[i]  = '0;
                        out_d[i]  = ~out_q[i];
                        tick_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end

                    // A stop lets the high phase finish so the last pulse is full width.
                    if (state_q[i] == S_PEND && term[i]) begin
                        if (sen_q[i]) begin
                            div_d[i]   = sdiv_q[i];
                            state_d[i] = S_RUN;
                        end else if (out_q[i]) begin
                            state_d[i] = S_IDLE;
                        end
                    end

                    if (state_q[i] == S_RUN && wr[i]) begin
                        sdiv_d[i]  = cfg.cfg_div;
                        sen_d[i]   = cfg.cfg_en;
                        state_d[i] = S_PEND;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other one.
    always_ff @(posedge clk200M_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_RUN;
                cnt_q[i]   <= '0;
                sdiv_q[i]  <= '0;
            end
            div_q[0] <= CNT_W'(DIV0_RST);
            div_q[1] <= CNT_W'(DIV1_RST);
            sen_q    <= '0;
            out_q    <= '0;
            tick_q   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                sdiv_q[i]  <= sdiv_d[i];
            end
            sen_q  <= sen_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign ch_out  = out_q;
    assign ch_tick = tick_q;

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Programmable two-channel clock-divider controller for the 200 MHz domain of the NICE coprocessor subsystem. Each channel generates a divided square wave plus a one-cycle tick strobe. Software-side logic can reprogram the divide ratio, or start and stop a channel, through a valid/ready config port. All updates are applied only at half-period boundaries, so outputs never produce runt pulses. After reset both channels run at the legacy rates: about 470 kHz on channel 0 and 10 MHz on channel 1.

## Interface
- CNT_W, 16, width of divide-ratio registers and counters
- DIV0_RST, 212, channel 0 terminal count after reset
- DIV1_RST, 9, channel 1 terminal count after reset
- clk200M_in  in  1  sole clock, 200 MHz
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; a transfer occurs when cfg_valid && cfg_ready at a clock edge
- cfg_sel  in  1  target channel (0/1)
- cfg_en  in  1  1 = run with cfg_div, 0 = stop channel
- cfg_div  in  CNT_W  terminal count (half-period = cfg_div+1 cycles); ignored when cfg_en=0
- ch_out  out  2  divided clock per channel (registered)
- ch_tick  out  2  one-cycle pulse on the edge where ch_out[i] changes
- ch_busy  out  2  channel i has an accepted, not-yet-applied update

## Operation
- Each channel has a counter cnt, an active divisor div, shadow registers (sdiv, sen) and a state IDLE/RUN/PEND.
- RUN:
  - cnt increments each cycle.
  - At cnt==div (terminal): cnt←0, ch_out toggles, ch_tick=1.
- IDLE: cnt=0, ch_out=0, ch_tick=0.
- cfg_ready = ~ch_busy[cfg_sel]. This is combinational on cfg_sel; the other channel is unaffected.
- Accepted write to an IDLE channel:
  - cfg_en=1: div←cfg_div, cnt←0, state→RUN.
  - cfg_en=0: no-op.
- Accepted write to a RUN channel: sdiv/sen captured, state→PEND, ch_busy=1.
- PEND counts with the old div. At the next terminal:
  - ch_out toggles normally.
  - sen=1: div←sdiv, state→RUN.
  - sen=0 and ch_out toggles 1→0: state→IDLE.
  - sen=0 and ch_out toggles 0→1: stay PEND; stop at the following terminal, after the full high phase completes.
  - ch_busy clears on the same edge the update takes effect.
- Write accepted in the same cycle as a terminal count: the terminal uses the old state. The update applies at the following terminal.
- cfg_div=0 is legal: output toggles every cycle (100 MHz).
- Widths: cnt and div are CNT_W bits unsigned. Comparison is equality, so there is no wrap beyond div.

## Timing
- Reset values (async assert, take effect immediately):
  - ch_out=0, ch_tick=0, ch_busy=0, cnt=0.
  - div0=DIV0_RST, div1=DIV1_RST.
  - Both channels in RUN.
- After rst_n deasserts, the first ch_out[i] rise occurs at clock edge div_i+1; falls follow every div_i+1 edges.
- Output period = 2·(div+1) cycles: 426 cycles (469.48 kHz) for ch0, 20 cycles (10 MHz) for ch1.
- Start from IDLE: the write is accepted at edge E. The first rise is at edge E+div+1.
- ch_tick[i] is high exactly during the first cycle of each new ch_out[i] level.
- Reset mid-operation: all state returns to reset values asynchronously. Pending updates are discarded.
- Channels are fully independent. Simultaneous terminals on both channels are handled in the same cycle.

## Test plan
- Reset release, no config → ch1 rises at edge 10 and falls at edge 20, period 20; ch0 rises at edge 213, period 426; one tick per transition; ch_busy=00.
- ch1 running div=9; write sel=1, en=1, div=4 at edge 5 → ch_busy[1]=1 and cfg_ready low for sel=1 until edge 10. Toggle at edge 10 still uses div=9, then toggles every 5 cycles.
- ch0 high phase; write en=0 → ch0 falls at the next terminal, stays 0 and goes IDLE; ch1 unaffected.
- ch0 low phase; write en=0 → ch0 rises at the next terminal, completes a full 213-cycle high, falls, then IDLE; ch_busy[0] clears on the falling edge.
- IDLE ch0; write en=1, div=0 at edge E → ch_out[0] toggles at E+1, E+2, …; a second write while busy is held off (cfg_ready=0) until applied.
- Assert rst_n low mid-PEND on ch1 → ch_out=00, ch_busy=00 immediately; after release the legacy timing of the first scenario repeats exactly.
